// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//   Direct-mapped instruction cache with one-word blocks. It answers the
//   datapath fetch port (imemREN/imemaddr -> ihit/imemload) and fills misses
//   from the memory controller instruction port (iREN/iaddr -> iwait/iload).
//   It also keeps hit and miss counters for performance tests.
//
// Ports
//   CLK, nRST            clock; synchronous active-low reset
//   imemREN, imemaddr    fetch request and byte address ([1:0] ignored)
//   ihit, imemload       zero-cycle hit flag and instruction word
//   inv                  one-cycle pulse that invalidates every frame
//   iREN, iaddr          fill request and word-aligned fill address
//   iwait, iload         memory busy flag and fill data
//   hit_cnt, miss_cnt    cycles with ihit==1 / misses accepted
//   dbg_state            current FSM state (0 = IDLE, 1 = FETCH)
//
// Handshake: in FETCH, iREN is held high with iaddr stable. The fill word is
// taken in the first cycle where iwait==0, and the FSM returns to IDLE at
// that edge. On the datapath side, ihit==1 means imemload is valid for
// imemaddr in this same cycle. There is no backpressure beyond the datapath
// re-presenting its request.
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int FRAMES = 16,
  parameter int CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             inv,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             dbg_state
);

  localparam int IDX_W = $clog2(FRAMES);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [FRAMES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [FRAMES];
  logic [31:0]       data_q [FRAMES];

  // The fill address is kept as a word address; the byte offset is always 0.
  logic [29:0] miss_word_q, miss_word_d;

  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             lookup_hit;
  logic             fill_we;
  logic             miss_take;

  // The byte offset of a fetch address plays no part in the lookup.
  logic unused_offset;
  assign unused_offset = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_word_q[IDX_W-1:0];
  assign fill_tag = miss_word_q[29:IDX_W];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    miss_word_d = miss_word_q;
    ihit        = 1'b0;
    imemload    = 32'h0;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    fill_we     = 1'b0;
    miss_take   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // inv suppresses both the hit and a new miss in the same cycle.
        if (imemREN && !inv) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end else begin
            miss_take   = 1'b1;
            miss_word_d = imemaddr[31:2];
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_word_q, 2'b00};
        // inv wins over a fill completing in the same cycle.
        if (inv) begin
          state_d = IDLE;
        end else if (!iwait) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, fill address, valid bits and counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_word_q <= '0;
      valid_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_word_q <= miss_word_d;
      if (inv) begin
        valid_q <= '0;
      end else if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
      if (ihit) begin
        hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      if (miss_take) begin
        miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q guards them.
  always_ff @(posedge CLK) begin
    if (fill_we && nRST && !inv) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign dbg_state = state_q;

endmodule
